// File: rtl/ras_ckpt_pkg.sv
// Shared types for the return address stack: default PC alias and the
// per-cycle stack operation decoded from push/pop requests.
package ras_ckpt_pkg;

  localparam int PC_WIDTH_DEFAULT = 38;

  typedef logic [PC_WIDTH_DEFAULT-1:0] PC_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } ras_op_e;

  function automatic ras_op_e decode_op(input logic push, input logic pop);
    ras_op_e op;
    op = OP_NONE;
    if (push && pop) op = OP_SWAP;
    else if (push)   op = OP_PUSH;
    else if (pop)    op = OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/ras_ckpt.sv
// Circular return address stack with push/pop/swap, checkpoint export and
// atomic restore of {index, count} after a mispredict.
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int RAS_ENTRIES   = 16,
  parameter int PC_WIDTH      = PC_WIDTH_DEFAULT,
  parameter bit OVERFLOW_WRAP = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push_valid,
  input  logic [PC_WIDTH-1:0]          push_pc,
  input  logic                         pop_valid,
  input  logic                         restore_valid,
  input  logic [$clog2(RAS_ENTRIES)-1:0] restore_ras_index,
  input  logic [$clog2(RAS_ENTRIES):0]   restore_ras_count,
  output logic                         ret_valid,
  output logic [PC_WIDTH-1:0]          ret_pc,
  output logic [$clog2(RAS_ENTRIES)-1:0] ras_index,
  output logic [$clog2(RAS_ENTRIES):0]   ras_count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int IW = $clog2(RAS_ENTRIES);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_ENTRIES);

  if (RAS_ENTRIES < 2 || (RAS_ENTRIES & (RAS_ENTRIES - 1)) != 0) begin : g_bad_depth
    $error("ras_ckpt: RAS_ENTRIES must be a power of two >= 2");
  end

  logic [PC_WIDTH-1:0] entries [RAS_ENTRIES];
  logic [IW-1:0]       sp_reg, sp_next;
  logic [CW-1:0]       count_reg, count_next;
  logic                overflow_reg, overflow_next;
  logic                underflow_reg, underflow_next;
  logic                wr_en;
  logic [IW-1:0]       wr_idx;
  logic [IW-1:0]       top_idx;
  logic                full, empty;
  ras_op_e             op;

  assign top_idx = sp_reg - IW'(1);
  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign op      = decode_op(push_valid, pop_valid);

  always_comb begin
    sp_next        = sp_reg;
    count_next     = count_reg;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    wr_en          = 1'b0;
    wr_idx         = sp_reg;
    if (restore_valid) begin
      sp_next    = restore_ras_index;
      count_next = (restore_ras_count > FULL_COUNT) ? FULL_COUNT : restore_ras_count;
    end else begin
      unique case (op)
        OP_SWAP: begin
          // Empty stack has nothing to replace, so a swap degrades to a push.
          if (!empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
          end else begin
            wr_en      = 1'b1;
            sp_next    = sp_reg + IW'(1);
            count_next = count_reg + CW'(1);
          end
        end
        OP_PUSH: begin
          if (!full) begin
            wr_en      = 1'b1;
            sp_next    = sp_reg + IW'(1);
            count_next = count_reg + CW'(1);
          end else begin
            overflow_next = 1'b1;
            if (OVERFLOW_WRAP) begin
              wr_en   = 1'b1;
              sp_next = sp_reg + IW'(1);
            end
          end
        end
        OP_POP: begin
          if (!empty) begin
            sp_next    = top_idx;
            count_next = count_reg - CW'(1);
          end else begin
            underflow_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp_reg        <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      for (int i = 0; i < RAS_ENTRIES; i++) entries[i] <= '0;
    end else begin
      sp_reg        <= sp_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      if (wr_en) entries[wr_idx] <= push_pc;
      if (restore_valid) begin
        assert (restore_ras_count <= FULL_COUNT);
      end
    end
  end

  assign ret_valid = !empty;
  assign ret_pc    = entries[top_idx];
  assign ras_index = sp_reg;
  assign ras_count = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule
